dmem_lsu_ctrl: RTL and testbench
================================

Name: dmem_lsu_ctrl

Overview:
- Initiator-side controller for the 32-bit single-port data RAM, which has byte write enables, no output register and 1-cycle read latency.
- Accepts byte/half/word load/store requests from the RISC-V core's memory stage.
- Drives the RAM port: address, write data, write enable and byte enables.
- Aligns and sign/zero-extends read data, and reports range/alignment errors.

Parameters:
- ADDR_WIDTH, 13, RAM word-address width (RAM holds 2^ADDR_WIDTH 32-bit words).
- BASE_ADDR, 32'h0000_0000, byte address of RAM word 0; must be 4-byte aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extend (LBU/LHU); ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  access error, qualified by rsp_valid.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- ram_addr  out  ADDR_WIDTH  RAM word address.
- ram_wr_data  out  32  RAM write data, lane-shifted.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_byte_en  out  4  RAM byte enables.
- ram_rd_data  in  32  RAM read data, valid the cycle after the address edge.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - ram_wr_en=0, ram_wr_byte_en=0, ram_addr=0, ram_wr_data=0.
- Offset and word index: off = req_addr - BASE_ADDR; word = off[ADDR_WIDTH+1:2]; lane = off[1:0].
- Range error: off >= 4*2^ADDR_WIDTH, or req_addr < BASE_ADDR.
- Misaligned: half with lane==3 or lane odd; word with lane!=0. Misalignment is an error unless the feature below is enabled. req_size==11 is an error.
- Handshake: accept = req_valid & req_ready. req_ready=1 only in IDLE.
- RAM drive: in IDLE the RAM signals are driven combinationally from the request, gated by req_valid and "no error", so the RAM samples at the acceptance edge. Otherwise ram_wr_en=0 and ram_wr_byte_en=0.
- Store:
  - ram_wr_en=1, byte_en = size mask << lane (byte 0001, half 0011, word 1111).
  - ram_wr_data = req_wdata replicated per lane and shifted to the lane.
  - rsp_valid=1, rsp_err=0 the cycle after acceptance. Stay IDLE, so back-to-back stores run at 1/cycle.
- Load:
  - ram_wr_en=0; go to RD_WAIT, latching size/unsigned/lane.
  - In RD_WAIT: select bytes of ram_rd_data by lane, extend, register into rsp_rdata; return to IDLE.
  - rsp_valid pulses 2 cycles after acceptance. Throughput is 1 load per 2 cycles.
- Error: no RAM write, ram_wr_en stays 0. rsp_valid=1, rsp_err=1, rsp_rdata=0 the cycle after acceptance. Stay IDLE.
- rsp_valid is always a single-cycle pulse. There is no rsp backpressure; the consumer must sample it.
- Reset mid-operation: any outstanding load is dropped and no rsp is produced.

Optional Feature:
- Macro: DMEM_MISALIGN_SPLIT_EN.
- Without it: every misaligned access is a 1-cycle error response.
- With it, a misaligned half/word spanning words N and N+1 is split into two accesses.
  - Extra states: ST_HI (store second word) and LD_LO/LD_HI (loads).
  - Store: low part written to word N at the acceptance edge. High part written to N+1 in ST_HI; byte_en = remaining low lanes. rsp_valid 2 cycles after acceptance.
  - Load: read N, then N+1, concatenate and extract; rsp_valid 3 cycles after acceptance.
  - If N+1 is out of range, the whole request errors before any RAM access.
  - Reset between halves may leave the low half written; this is accepted.
  - req_ready=0 throughout a split.
  - A misaligned access within one word (e.g. half at lane 1) is single-access and is never split.

Decomposition:
- Package dmem_pkg holds:
  - SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10;
  - state encoding IDLE/RD_WAIT/ST_HI/LD_LO/LD_HI;
  - size-to-mask function.
- Sub-module dmem_align: combinational store lane shift/byte-enable generation plus load extract/extend. It is shared by single and split paths.

Test Plan:
1. Reset, then word store 0xDEADBEEF @BASE+0x10 -> ram_addr=4, byte_en=1111 in the accept cycle; rsp_valid 1 cycle later, err=0.
2. LB @BASE+0x13 after the store -> rsp_rdata=0xFFFFFFDE 2 cycles after accept. LBU -> 0x000000DE. LHU @+0x12 -> 0x0000DEAD.
3. SH 0x1234 @BASE+0x06 -> byte_en=1100, ram_wr_data[31:16]=0x1234. Two back-to-back SB at 1/cycle with no stall.
4. LW @BASE+0x8000 (ADDR_WIDTH=13) and req_size=11 -> ram_wr_en stays 0; rsp_err=1, rsp_rdata=0 the next cycle.
5. Misaligned LW @BASE+0x2: without macro -> err. With macro, after words 0=0x44332211 and 1=0x88776655 -> 0x66554433 after 3 cycles.
6. Assert rst_n=0 during RD_WAIT -> no rsp_valid; req_ready=1 immediately after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size codes, FSM states and byte-mask helper for the data RAM controller
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        ST_HI   = 3'd2,
        LD_LO   = 3'd3,
        LD_HI   = 3'd4
    } state_e;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return 4'b0001;
            SIZE_H:  return 4'b0011;
            SIZE_W:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - store lane shift / byte enables and load extract / extend over a two-word window
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [31:0] wr_lo_o,
    output logic [31:0] wr_hi_o,
    output logic [3:0]  be_lo_o,
    output logic [3:0]  be_hi_o,
    output logic [31:0] rd_ext_o
);

    logic [31:0] rep;
    logic [63:0] wshift;
    logic [7:0]  be8;
    logic [31:0] rsh;

    always_comb begin
        case (size_i)
            SIZE_B:  rep = {4{wdata_i[7:0]}};
            SIZE_H:  rep = {2{wdata_i[15:0]}};
            default: rep = wdata_i;
        endcase
    end

    // Shifting across 64 bits puts the spill-over bytes of a word-crossing access in the upper word.
    assign wshift  = {32'd0, rep} << {lane_i, 3'b000};
    assign be8     = {4'd0, size_mask(size_i)} << lane_i;
    assign wr_lo_o = wshift[31:0];
    assign wr_hi_o = wshift[63:32];
    assign be_lo_o = be8[3:0];
    assign be_hi_o = be8[7:4];

    assign rsh = 32'(rdata_i >> {lane_i, 3'b000});

    always_comb begin
        case (size_i)
            SIZE_B:  rd_ext_o = unsigned_i ? {24'd0, rsh[7:0]}   : {{24{rsh[7]}}, rsh[7:0]};
            SIZE_H:  rd_ext_o = unsigned_i ? {16'd0, rsh[15:0]}  : {{16{rsh[15]}}, rsh[15:0]};
            SIZE_W:  rd_ext_o = rsh;
            default: rd_ext_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// rtl/dmem_lsu_ctrl.sv - data RAM load/store controller; define DMEM_MISALIGN_SPLIT_EN to split word-crossing accesses
module dmem_lsu_ctrl
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 13,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wr_data,
    output logic                  ram_wr_en,
    output logic [3:0]            ram_wr_byte_en,
    input  logic [31:0]           ram_rd_data
);

    state_e                state_q;
    logic [1:0]            size_q;
    logic [1:0]            lane_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] addr_hi_q;
    logic [31:0]           wdata_hi_q;
    logic [3:0]            be_hi_q;
    logic [31:0]           lo_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [31:0]           rsp_rdata_q;

    logic [31:0]           off;
    logic [1:0]            lane;
    logic [ADDR_WIDTH-1:0] word;
    logic                  range_err;
    logic                  illegal;
    logic                  err;
    logic                  split;

    assign off       = req_addr - BASE_ADDR;
    assign lane      = off[1:0];
    assign word      = off[ADDR_WIDTH+1:2];
    assign range_err = (req_addr < BASE_ADDR) || ((off >> (ADDR_WIDTH + 2)) != 32'd0);
    assign illegal   = (req_size == 2'b11);

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic spans;
    assign spans = ((req_size == SIZE_H) && (lane == 2'd3)) ||
                   ((req_size == SIZE_W) && (lane != 2'd0));
    // A crossing access whose second word would fall off the RAM is refused before touching either word.
    assign err   = range_err || illegal || (spans && (&word));
    assign split = spans && !err;
`else
    logic misal;
    assign misal = ((req_size == SIZE_H) && lane[0]) ||
                   ((req_size == SIZE_W) && (lane != 2'd0));
    assign err   = range_err || illegal || misal;
    assign split = 1'b0;
`endif

    logic        idle;
    logic [1:0]  a_size;
    logic [1:0]  a_lane;
    logic        a_uns;
    logic [63:0] a_rdata;
    logic [31:0] wr_lo;
    logic [31:0] wr_hi;
    logic [3:0]  be_lo;
    logic [3:0]  be_hi;
    logic [31:0] rd_ext;

    assign idle    = (state_q == IDLE);
    assign a_size  = idle ? req_size : size_q;
    assign a_lane  = idle ? lane : lane_q;
    assign a_uns   = idle ? req_unsigned : uns_q;
    assign a_rdata = (state_q == LD_HI) ? {ram_rd_data, lo_q} : {32'd0, ram_rd_data};

    dmem_align u_align (
        .size_i     (a_size),
        .lane_i     (a_lane),
        .unsigned_i (a_uns),
        .wdata_i    (req_wdata),
        .rdata_i    (a_rdata),
        .wr_lo_o    (wr_lo),
        .wr_hi_o    (wr_hi),
        .be_lo_o    (be_lo),
        .be_hi_o    (be_hi),
        .rd_ext_o   (rd_ext)
    );

    // The RAM samples its port at the acceptance edge, so the IDLE drive comes straight from the request.
    always_comb begin
        ram_addr       = '0;
        ram_wr_data    = 32'd0;
        ram_wr_en      = 1'b0;
        ram_wr_byte_en = 4'd0;
        case (state_q)
            IDLE: begin
                if (req_valid && !err) begin
                    ram_addr = word;
                    if (req_we) begin
                        ram_wr_en      = 1'b1;
                        ram_wr_byte_en = be_lo;
                        ram_wr_data    = wr_lo;
                    end
                end
            end
            ST_HI: begin
                ram_addr       = addr_hi_q;
                ram_wr_en      = 1'b1;
                ram_wr_byte_en = be_hi_q;
                ram_wr_data    = wdata_hi_q;
            end
            LD_LO:   ram_addr = addr_hi_q;
            default: ram_addr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            size_q      <= SIZE_B;
            lane_q      <= 2'd0;
            uns_q       <= 1'b0;
            addr_hi_q   <= '0;
            wdata_hi_q  <= 32'd0;
            be_hi_q     <= 4'd0;
            lo_q        <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        size_q     <= req_size;
                        lane_q     <= lane;
                        uns_q      <= req_unsigned;
                        addr_hi_q  <= word + ADDR_WIDTH'(1);
                        wdata_hi_q <= wr_hi;
                        be_hi_q    <= be_hi;
                        if (err) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (split) begin
                            state_q <= req_we ? ST_HI : LD_LO;
                        end else if (req_we) begin
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= rd_ext;
                    state_q     <= IDLE;
                end
                ST_HI: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                LD_LO: begin
                    lo_q    <= ram_rd_data;
                    state_q <= LD_HI;
                end
                LD_HI: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= rd_ext;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = idle;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// tb/tb_dmem_lsu_ctrl.sv - scoreboard bench for dmem_lsu_ctrl against a byte-addressed memory model
module tb_dmem_lsu_ctrl;

    localparam int          AW     = 13;
    localparam logic [31:0] BASE   = 32'h2000_0000;
    localparam int          NWORDS = 1 << AW;
    localparam int          NBYTES = 4 * NWORDS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_err;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wr_data;
    logic          ram_wr_en;
    logic [3:0]    ram_wr_byte_en;
    logic [31:0]   ram_rd_data;

    dmem_lsu_ctrl #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_err        (rsp_err),
        .rsp_rdata      (rsp_rdata),
        .ram_addr       (ram_addr),
        .ram_wr_data    (ram_wr_data),
        .ram_wr_en      (ram_wr_en),
        .ram_wr_byte_en (ram_wr_byte_en),
        .ram_rd_data    (ram_rd_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [7:0]  refb [0:NBYTES-1];
    logic [31:0] ram  [0:NWORDS-1];
    logic        ram_init;

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < NWORDS; i++) ram[i] <= init_word(i);
        end else if (ram_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wr_byte_en[b]) ram[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
        end
        ram_rd_data <= ram[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp got rsp_valid=1 required no response (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                chk("rsp_latency", cyc, mon_e.due);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Drives one request, checks the RAM port in the acceptance cycle and queues the expected response.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input bit want, output int acc);
        longint      off;
        int          n, lane, lat, w;
        logic        err, spans;
        logic [3:0]  be;
        logic [31:0] wl, rd, m;
        exp_t        e;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        #1;
        w = 0;
        while (!req_ready && w < 8) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off   = longint'(a) - longint'(BASE);
        err   = (sz == 2'd3) || (off < 0) || (off + n > NBYTES);
        lane  = err ? 0 : int'(off % 4);
        spans = !err && (lane + n > 4);
`ifndef DMEM_MISALIGN_SPLIT_EN
        if (!err && (off % n) != 0) begin
            err   = 1'b1;
            spans = 1'b0;
        end
`endif
        lat = err ? 1 : (we ? (spans ? 2 : 1) : (spans ? 3 : 2));
        be = 4'd0; wl = 32'd0; rd = 32'd0;
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                if (lane + i < 4) begin
                    be[lane+i]           = 1'b1;
                    wl[8*(lane+i) +: 8]  = wd[8*i +: 8];
                end
                if (we) refb[int'(off) + i] = wd[8*i +: 8];
                else    rd[8*i +: 8]        = refb[int'(off) + i];
            end
            if (!we && !uns && rd[8*n-1])
                for (int j = n; j < 4; j++) rd[8*j +: 8] = 8'hFF;
        end
        if (err) begin
            chk("err_no_write", 32'(ram_wr_en), 32'd0);
            chk("err_byte_en", 32'(ram_wr_byte_en), 32'd0);
        end else begin
            chk("ram_addr", 32'(ram_addr), 32'(off >> 2));
            chk("ram_wr_en", 32'(ram_wr_en), 32'(we));
            if (we) begin
                for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
                chk("ram_byte_en", 32'(ram_wr_byte_en), 32'(be));
                chk("ram_wr_data", ram_wr_data & m, wl & m);
            end
        end
        acc = cyc;
        if (want) begin
            e.err   = err;
            e.rdata = (err || we) ? 32'd0 : rd;
            e.due   = acc + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        int          acc, a1, a2, r;
        logic [31:0] wv, a;
        logic [1:0]  sz;
        rst_n = 1'b0; ram_init = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < NWORDS; i++) begin
            wv = init_word(i);
            for (int b = 0; b < 4; b++) refb[4*i + b] = wv[8*b +: 8];
        end
        repeat (3) @(negedge clk);
        ram_init = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_ram_byte_en", 32'(ram_wr_byte_en), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wr_data", ram_wr_data, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        issue(1'b1, 2'd2, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 1'b1, acc);
        issue(1'b0, 2'd0, 1'b0, BASE + 32'h13, 32'd0, 1'b1, acc);
        issue(1'b0, 2'd0, 1'b1, BASE + 32'h13, 32'd0, 1'b1, acc);
        issue(1'b0, 2'd1, 1'b1, BASE + 32'h12, 32'd0, 1'b1, acc);

        issue(1'b1, 2'd1, 1'b0, BASE + 32'h06, 32'h0000_1234, 1'b1, acc);
        issue(1'b1, 2'd0, 1'b0, BASE + 32'h20, 32'h0000_00A5, 1'b1, a1);
        issue(1'b1, 2'd0, 1'b0, BASE + 32'h21, 32'h0000_005A, 1'b1, a2);
        chk("sb_back_to_back", a2, a1 + 1);
        issue(1'b0, 2'd1, 1'b0, BASE + 32'h20, 32'd0, 1'b1, acc);
        issue(1'b0, 2'd1, 1'b1, BASE + 32'h06, 32'd0, 1'b1, acc);

        issue(1'b0, 2'd2, 1'b0, BASE + 32'h8000, 32'd0, 1'b1, acc);
        issue(1'b1, 2'd3, 1'b0, BASE + 32'h10, 32'h1111_2222, 1'b1, acc);
        issue(1'b0, 2'd2, 1'b0, BASE - 32'h4, 32'd0, 1'b1, acc);

        issue(1'b1, 2'd2, 1'b0, BASE, 32'h4433_2211, 1'b1, acc);
        issue(1'b1, 2'd2, 1'b0, BASE + 32'h4, 32'h8877_6655, 1'b1, acc);
        issue(1'b0, 2'd2, 1'b0, BASE + 32'h2, 32'd0, 1'b1, acc);
        issue(1'b0, 2'd1, 1'b0, BASE + 32'h3, 32'd0, 1'b1, acc);
        issue(1'b0, 2'd2, 1'b0, BASE + 32'h7FFE, 32'd0, 1'b1, acc);

        repeat (4) @(negedge clk);
        issue(1'b0, 2'd2, 1'b0, BASE + 32'h10, 32'd0, 1'b0, acc);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid_a", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("midrst_rsp_valid_b", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);

        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 5)       a = BASE - 32'($urandom_range(1, 16));
            else if (r < 10) a = BASE + 32'h8000 + 32'($urandom_range(0, 16));
            else if (r < 20) a = BASE + 32'h8000 - 32'($urandom_range(1, 8));
            else if (r < 25) a = $urandom;
            else             a = BASE + 32'($urandom_range(0, 63));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b1, acc);
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
